uart_rx_deframer: RTL and testbench

//  Receive-side deframer for the UART-Rx path. Sits directly downstream of the

---
 rtl/uart_rx_deframer.sv | 123 ++++++++++++
 tb/tb_uart_rx_deframer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - UART receive deframer driven by bit-centre toggles from the baud sampling stage
// Samples the synchronised line on each BaudOut edge and assembles start/data/parity/stop into a byte.
module uart_rx_deframer #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  DataTx,
  input  logic                  BaudOut,
  input  logic                  ParityType,
  output logic [DATA_WIDTH-1:0] RxData,
  output logic                  Done,
  output logic                  ParityError,
  output logic                  StopError,
  output logic                  Busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                  state, stateNext;
  logic [SYNC_STAGES-1:0]  syncQ;
  logic                    baudOutQ;
  logic                    tick;
  logic                    rxBit;
  logic [DATA_WIDTH-1:0]   shreg, shregNext;
  logic [CW-1:0]           count, countNext;
  logic                    parityTypeQ, parityTypeNext;
  logic                    pbit, pbitNext;
  logic [DATA_WIDTH-1:0]   rxDataNext;
  logic                    doneNext, parityErrorNext, stopErrorNext;

  assign tick  = BaudOut ^ baudOutQ;
  assign rxBit = syncQ[SYNC_STAGES-1];
  assign Busy  = (state != IDLE);

  // Synchroniser resets to ones so the line looks idle coming out of reset.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      syncQ    <= '1;
      baudOutQ <= 1'b0;
    end else begin
      syncQ    <= {syncQ[SYNC_STAGES-2:0], DataTx};
      baudOutQ <= BaudOut;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      shreg       <= '0;
      count       <= '0;
      parityTypeQ <= 1'b0;
      pbit        <= 1'b0;
      RxData      <= '0;
      Done        <= 1'b0;
      ParityError <= 1'b0;
      StopError   <= 1'b0;
    end else begin
      state       <= stateNext;
      shreg       <= shregNext;
      count       <= countNext;
      parityTypeQ <= parityTypeNext;
      pbit        <= pbitNext;
      RxData      <= rxDataNext;
      Done        <= doneNext;
      ParityError <= parityErrorNext;
      StopError   <= stopErrorNext;
    end
  end

  always_comb begin
    stateNext       = state;
    shregNext       = shreg;
    countNext       = count;
    parityTypeNext  = parityTypeQ;
    pbitNext        = pbit;
    rxDataNext      = RxData;
    doneNext        = 1'b0;
    parityErrorNext = ParityError;
    stopErrorNext   = StopError;
    case (state)
      IDLE: begin
        // A high sample here is an idle toggle or the trailing toggle after a stop bit.
        if (tick && !rxBit) begin
          stateNext      = DATA;
          countNext      = '0;
          parityTypeNext = ParityType;
        end
      end
      DATA: begin
        if (tick) begin
          shregNext = {rxBit, shreg[DATA_WIDTH-1:1]};
          if (count == CW'(DATA_WIDTH - 1)) begin
            countNext = '0;
            stateNext = PARITY;
          end else begin
            countNext = count + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          pbitNext  = rxBit;
          stateNext = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          rxDataNext      = shreg;
          parityErrorNext = (^shreg) ^ pbit ^ parityTypeQ;
          stopErrorNext   = ~rxBit;
          doneNext        = 1'b1;
          stateNext       = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - scoreboard bench for uart_rx_deframer
// Directed frames push hand-computed results; a monitor pops and compares on every Done.
module tb_uart_rx_deframer;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic       DataTx;
  logic       BaudOut;
  logic       ParityType;
  logic [7:0] RxData;
  logic       Done;
  logic       ParityError;
  logic       StopError;
  logic       Busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  logic doneLast = 1'b0;

  uart_rx_deframer #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .Clock(Clock), .ResetN(ResetN), .DataTx(DataTx), .BaudOut(BaudOut),
    .ParityType(ParityType), .RxData(RxData), .Done(Done),
    .ParityError(ParityError), .StopError(StopError), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every Done pops one expected frame.
  always @(negedge Clock) begin
    if (ResetN === 1'b1 && Done === 1'b1) begin
      exp_t e;
      check("done_not_consecutive", {31'd0, doneLast}, 32'd0);
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got RxData %0h want no Done", RxData);
      end else begin
        e = expQ.pop_front();
        check("rxdata", {24'd0, RxData}, {24'd0, e.data});
        check("parity_error", {31'd0, ParityError}, {31'd0, e.perr});
        check("stop_error", {31'd0, StopError}, {31'd0, e.serr});
      end
    end
    doneLast = Done;
  end

  // kind: 0 start, 1 data/parity, 2 stop, 3 idle toggle
  task automatic sendBit(input logic b, input int kind);
    logic [7:0] rxBefore;
    rxBefore = RxData;
    DataTx = b;
    repeat (4) @(negedge Clock);
    BaudOut = ~BaudOut;
    @(negedge Clock);
    case (kind)
      0: check("busy_after_start", {31'd0, Busy}, 32'd1);
      2: begin
        check("done_latency", {31'd0, Done}, 32'd1);
        check("busy_after_stop", {31'd0, Busy}, 32'd0);
      end
      3: begin
        check("idle_busy", {31'd0, Busy}, 32'd0);
        check("idle_rxdata", {24'd0, RxData}, {24'd0, rxBefore});
      end
      default: ;
    endcase
    repeat (3) @(negedge Clock);
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic ptype, input logic pb,
                           input logic stopB, input logic perrExp);
    expQ.push_back('{data: data, perr: perrExp, serr: ~stopB});
    ParityType = ptype;
    sendBit(1'b0, 0);
    ParityType = ~ptype;
    for (int i = 0; i < 8; i++) sendBit(data[i], 1);
    sendBit(pb, 1);
    sendBit(stopB, 2);
  endtask

  task automatic idleBits(input int n);
    for (int i = 0; i < n; i++) sendBit(1'b1, 3);
  endtask

  initial begin
    ResetN     = 1'b0;
    DataTx     = 1'b1;
    BaudOut    = 1'b0;
    ParityType = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset_rxdata", {24'd0, RxData}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_perr", {31'd0, ParityError}, 32'd0);
    check("reset_serr", {31'd0, StopError}, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    ResetN = 1'b1;
    repeat (3) @(negedge Clock);
    idleBits(2);

    // 0xA5: four ones, even parity bit 0 is correct
    sendFrame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    idleBits(2);
    // 0x5A under odd parity needs bit 1; bit 0 is wrong
    sendFrame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
    idleBits(2);
    // 0x07 under odd parity: three ones, bit 0 is correct
    sendFrame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    idleBits(2);
    // 0x0F, even parity bit 0 correct, stop bit low
    sendFrame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);

    idleBits(20);
    check("idle_rxdata_kept", {24'd0, RxData}, 32'h0F);
    check("idle_stop_error_kept", {31'd0, StopError}, 32'd1);

    // Partial 0xFF frame, then reset
    ParityType = 1'b0;
    sendBit(1'b0, 0);
    for (int i = 0; i < 4; i++) sendBit(1'b1, 1);
    DataTx  = 1'b1;
    BaudOut = 1'b0;
    ResetN  = 1'b0;
    repeat (2) @(negedge Clock);
    check("midreset_rxdata", {24'd0, RxData}, 32'd0);
    check("midreset_done", {31'd0, Done}, 32'd0);
    check("midreset_perr", {31'd0, ParityError}, 32'd0);
    check("midreset_serr", {31'd0, StopError}, 32'd0);
    check("midreset_busy", {31'd0, Busy}, 32'd0);
    ResetN = 1'b1;
    repeat (3) @(negedge Clock);
    idleBits(1);
    sendFrame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);

    idleBits(1);
    // Back-to-back: next start on the toggle right after the stop bit
    sendFrame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    sendFrame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    idleBits(2);

    repeat (10) @(negedge Clock);
    check("queue_drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
